// File: rtl/display_scan_controller_if.sv
// Digit-update handshake between the value producer and the scan controller.
// The producer holds digits_in stable while update_req is high.
interface display_scan_controller_if #(
  parameter int NUM_DIGITS = 2
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    update_req;
  logic                    update_ack;

  modport master (
    output digits_in,
    output update_req,
    input  update_ack
  );

  modport slave (
    input  digits_in,
    input  update_req,
    output update_ack
  );
endinterface

// File: rtl/display_scan_controller.sv
// Multiplexed seven-segment scan with blanking gaps and frame-aligned updates.
// Optional brightness dimming is enabled by defining DISP_DIM_EN.
module display_scan_controller #(
  parameter int NUM_DIGITS   = 2,
  parameter int DWELL_CYCLES = 48000,
  parameter int BLANK_CYCLES = 480
) (
  input  logic                      clk,
  input  logic                      reset_n,
  display_scan_controller_if.slave  upd,
`ifdef DISP_DIM_EN
  input  logic [3:0]                bright,
`endif
  output logic [3:0]                nibble,
  output logic [NUM_DIGITS-1:0]     anode_n,
  output logic                      frame_start
);

  localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ?
                        DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;

  localparam logic [CW-1:0] DW_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BL_LAST =
    (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [0:0]                  state_q, state_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0][3:0]  shadow_q, shadow_d;
  logic                        init_q;
  logic [3:0]                  nibble_q, nibble_d;
  logic [NUM_DIGITS-1:0]       anode_q, anode_d;
  logic                        ack_q, ack_d;
  logic                        fs_q, fs_d;

  logic blank_done;
  logic on_done;
  logic last_dig;
  logic boundary;
  logic on_entry;
  logic lit;

  assign blank_done = (state_q == ST_BLANK) &&
                      ((BLANK_CYCLES == 0) || (cnt_q == BL_LAST));
  assign on_done    = (state_q == ST_ON) && (cnt_q == DW_LAST);
  assign last_dig   = (idx_q == IDX_LAST);
  // The first blank after reset counts as a frame boundary too.
  assign boundary   = init_q || (on_done && last_dig);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    on_entry = 1'b0;
    unique case (1'b1)
      blank_done: begin
        state_d  = ST_ON;
        cnt_d    = '0;
        on_entry = 1'b1;
      end
      on_done: begin
        idx_d = last_dig ? '0 : idx_q + 1'b1;
        cnt_d = '0;
        if (BLANK_CYCLES == 0) begin
          state_d  = ST_ON;
          on_entry = 1'b1;
        end else begin
          state_d = ST_BLANK;
        end
      end
      default: cnt_d = cnt_q + 1'b1;
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    ack_d    = 1'b0;
    if (boundary && upd.update_req) begin
      shadow_d = upd.digits_in;
      ack_d    = 1'b1;
    end
  end

`ifdef DISP_DIM_EN
  logic [3:0]    bright_q, bright_d;
  logic [CW+4:0] lim;

  assign bright_d = on_entry ? bright : bright_q;
  assign lim = (CW+5)'({1'b0, bright_d} + 5'd1) *
               (CW+5)'(DWELL_CYCLES / 16);
  assign lit = (state_d == ST_ON) && ({5'b0, cnt_d} < lim);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bright_q <= '0;
    else          bright_q <= bright_d;
  end
`else
  assign lit = (state_d == ST_ON);
`endif

  always_comb begin
    nibble_d = shadow_d[idx_d];
    fs_d     = on_entry && (idx_d == '0);
    anode_d  = '1;
    if (lit) anode_d = ~(NUM_DIGITS'(1) << idx_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_BLANK;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      init_q   <= 1'b1;
      nibble_q <= '0;
      anode_q  <= '1;
      ack_q    <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      init_q   <= 1'b0;
      nibble_q <= nibble_d;
      anode_q  <= anode_d;
      ack_q    <= ack_d;
      fs_q     <= fs_d;
    end
  end

  assign nibble         = nibble_q;
  assign anode_n        = anode_q;
  assign frame_start    = fs_q;
  assign upd.update_ack = ack_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller (2 digits, blank 2).
// Dwell is 4 by default, 16 with DISP_DIM_EN for the dimming checks.
module tb_display_scan_controller;

`ifdef DISP_DIM_EN
  localparam int DW = 16;
`else
  localparam int DW = 4;
`endif
  localparam int BL = 2;
  localparam int PER = 2 * (DW + BL);

  logic       clk;
  logic       reset_n;
  logic [3:0] nibble;
  logic [1:0] anode_n;
  logic       frame_start;
`ifdef DISP_DIM_EN
  logic [3:0] bright;
`endif

  int errors;
  int checks;
  int k;

  display_scan_controller_if #(.NUM_DIGITS(2)) bus ();

  display_scan_controller #(
    .NUM_DIGITS  (2),
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .upd        (bus),
`ifdef DISP_DIM_EN
    .bright     (bright),
`endif
    .nibble     (nibble),
    .anode_n    (anode_n),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mpos();
    return (k - 1) % PER;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic goto(input int target);
    for (int i = 0; i < 2 * PER; i++) begin
      step();
      if (mpos() == target) return;
    end
    errors++;
    checks++;
    $display("FAIL goto: position %0d never reached", target);
  endtask

  task automatic chk_nib(input string nm, input logic [3:0] exp);
    checks++;
    if (nibble !== exp) begin
      errors++;
      $display("FAIL %s: nibble got %h want %h", nm, nibble, exp);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.update_req = 1'b0;
    bus.digits_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (anode_n !== 2'b11) begin
      errors++;
      $display("FAIL rst_anode: got %b want 11", anode_n);
    end
    chk_nib("rst_nibble", 4'h0);
    checks++;
    if (bus.update_ack !== 1'b0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL rst_pulses: ack %b fs %b want 0 0",
               bus.update_ack, frame_start);
    end
    reset_n = 1'b1;
    k = 0;
  endtask

  task automatic test_scan();
    logic [1:0] ea;
    logic       ef;
    for (int c = 1; c <= 24; c++) begin
      step();
      ea = 2'b11;
      if (mpos() >= 1 && mpos() <= 4) ea = 2'b10;
      if (mpos() >= 7 && mpos() <= 10) ea = 2'b01;
      ef = (mpos() == 1);
      checks++;
      if (anode_n !== ea || frame_start !== ef || nibble !== 4'h0) begin
        errors++;
        $display("FAIL scan@%0d: anode %b fs %b nib %h want %b %b 0",
                 c, anode_n, frame_start, nibble, ea, ef);
      end
    end
  endtask

  task automatic test_update();
    int ackm;
    ackm = -1;
    goto(3);
    bus.digits_in = 8'hA5;
    bus.update_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.update_ack === 1'b1) begin
        ackm = mpos();
        break;
      end
      if (mpos() == 4 || mpos() == 7) chk_nib("upd_oldframe", 4'h0);
    end
    checks++;
    if (ackm != 11) begin
      errors++;
      $display("FAIL upd_ack_pos: got %0d want 11", ackm);
    end
    chk_nib("upd_ackcycle", 4'h5);
    bus.update_req = 1'b0;
    step();
    checks++;
    if (bus.update_ack !== 1'b0) begin
      errors++;
      $display("FAIL upd_ack_once: got %b want 0", bus.update_ack);
    end
    goto(2);
    chk_nib("upd_d0", 4'h5);
    goto(8);
    chk_nib("upd_d1", 4'hA);
  endtask

  task automatic test_boundary();
    goto(10);
    bus.digits_in = 8'h3C;
    bus.update_req = 1'b1;
    step();
    checks++;
    if (bus.update_ack !== 1'b1) begin
      errors++;
      $display("FAIL bnd_ack: got %b want 1", bus.update_ack);
    end
    chk_nib("bnd_blank_d0", 4'hC);
    bus.update_req = 1'b0;
    goto(2);
    chk_nib("bnd_d0", 4'hC);
    goto(8);
    chk_nib("bnd_d1", 4'h3);
  endtask

  task automatic test_withdrawn();
    int acks;
    acks = 0;
    goto(3);
    bus.digits_in = 8'h77;
    bus.update_req = 1'b1;
    step();
    bus.update_req = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (bus.update_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL wd_ack: got %0d acks want 0", acks);
    end
    goto(2);
    chk_nib("wd_d0", 4'hC);
    goto(8);
    chk_nib("wd_d1", 4'h3);
  endtask

  task automatic test_reheld();
    int acks;
    acks = 0;
    bus.digits_in = 8'h96;
    bus.update_req = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      if (bus.update_ack === 1'b1) acks++;
    end
    bus.update_req = 1'b0;
    checks++;
    if (acks != 2) begin
      errors++;
      $display("FAIL reheld_acks: got %0d want 2", acks);
    end
    goto(2);
    chk_nib("reheld_d0", 4'h6);
  endtask

  task automatic test_reset_mid();
    goto(8);
    checks++;
    if (anode_n !== 2'b01) begin
      errors++;
      $display("FAIL rm_pre: anode %b want 01", anode_n);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (anode_n !== 2'b11) begin
      errors++;
      $display("FAIL rm_async: anode %b want 11", anode_n);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    k = 0;
    step();
    checks++;
    if (anode_n !== 2'b11) begin
      errors++;
      $display("FAIL rm_blank: anode %b want 11", anode_n);
    end
    step();
    checks++;
    if (anode_n !== 2'b10 || frame_start !== 1'b1) begin
      errors++;
      $display("FAIL rm_restart: anode %b fs %b want 10 1",
               anode_n, frame_start);
    end
    chk_nib("rm_d0", 4'h0);
    goto(8);
    chk_nib("rm_d1", 4'h0);
  endtask

`ifdef DISP_DIM_EN
  task automatic dim_run(input logic [3:0] b, input int exp);
    int lo0;
    int lo1;
    bit seen;
    lo0 = 0;
    lo1 = 0;
    seen = 1'b0;
    bright = b;
    for (int i = 0; i < 3 * PER; i++) begin
      step();
      if (frame_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    for (int i = 0; i < PER; i++) begin
      if (anode_n[0] === 1'b0) lo0++;
      if (anode_n[1] === 1'b0) lo1++;
      step();
    end
    checks++;
    if (!seen || lo0 != exp || lo1 != exp) begin
      errors++;
      $display("FAIL dim_b%0d: low %0d/%0d want %0d", b, lo0, lo1, exp);
    end
  endtask

  task automatic test_dim();
    dim_run(4'd3, 4);
    dim_run(4'd15, 16);
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    k = 0;
`ifdef DISP_DIM_EN
    bright = 4'hF;
    test_reset();
    test_dim();
`else
    test_reset();
    test_scan();
    test_update();
    test_boundary();
    test_withdrawn();
    test_reheld();
    test_reset_mid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
